// File: rtl/syn_gpu_pxl_gw_if.sv
// -----------------------------------------------------------------------------
// syn_gpu_pxl_gw_if.sv
// Bus bundles for the GPU pixel gateway.
//
// syn_gpu_pxl_gw_pxl_if  : pixel request/response channel from the anti-aliaser.
//   master (requester) drives pxl_wr_valid, pxl_rd_valid, posx, posy, pxl;
//   slave  (gateway)   drives ready, rd_rsp_valid, rd_rsp_pxl.
//
// syn_gpu_pxl_gw_sram_if : single-word request channel to the SRAM arbiter.
//   master (gateway)   drives sram_req, sram_we, sram_addr, sram_wdata;
//   slave  (arbiter)   drives sram_ack, sram_rd_valid, sram_rdata.
// -----------------------------------------------------------------------------
interface syn_gpu_pxl_gw_pxl_if #(
  parameter int P_X_W   = 10,
  parameter int P_Y_W   = 9,
  parameter int P_PXL_W = 16
);
  logic               pxl_wr_valid;
  logic               pxl_rd_valid;
  logic [P_X_W-1:0]   posx;
  logic [P_Y_W-1:0]   posy;
  logic [P_PXL_W-1:0] pxl;
  logic               ready;
  logic               rd_rsp_valid;
  logic [P_PXL_W-1:0] rd_rsp_pxl;

  modport master (
    output pxl_wr_valid, pxl_rd_valid, posx, posy, pxl,
    input  ready, rd_rsp_valid, rd_rsp_pxl
  );

  modport slave (
    input  pxl_wr_valid, pxl_rd_valid, posx, posy, pxl,
    output ready, rd_rsp_valid, rd_rsp_pxl
  );
endinterface

interface syn_gpu_pxl_gw_sram_if #(
  parameter int P_PXL_W  = 16,
  parameter int P_ADDR_W = 19
);
  logic                sram_req;
  logic                sram_we;
  logic [P_ADDR_W-1:0] sram_addr;
  logic [P_PXL_W-1:0]  sram_wdata;
  logic                sram_ack;
  logic                sram_rd_valid;
  logic [P_PXL_W-1:0]  sram_rdata;

  modport master (
    output sram_req, sram_we, sram_addr, sram_wdata,
    input  sram_ack, sram_rd_valid, sram_rdata
  );

  modport slave (
    input  sram_req, sram_we, sram_addr, sram_wdata,
    output sram_ack, sram_rd_valid, sram_rdata
  );
endinterface

// File: rtl/syn_gpu_pxl_gw.sv
// -----------------------------------------------------------------------------
// syn_gpu_pxl_gw.sv
// Pixel gateway downstream of the GPU anti-aliaser. Converts (posx,posy) pixel
// write/read requests into linear frame-buffer word addresses
// (addr = posy*P_FRM_W + posx, truncated to P_ADDR_W), issues one SRAM request
// at a time and returns read data to the requester.
//
// Ports
//   clk_ir      : clock
//   rst_sync_l  : asynchronous active-low reset
//   pif         : pixel channel (slave side) - valids, coordinates, write data,
//                 combinational ready, 1-cycle read response
//   sif         : SRAM arbiter channel (master side) - req held until ack,
//                 we/addr/wdata stable while req is high
//   drop_cnt    : saturating count of clipped pixels (0 when clipping is off)
//
// Build option
//   SYN_GPU_PXL_GW_CLIP_EN : when defined, requests outside the frame are
//                            dropped (no SRAM access, counted in drop_cnt, a
//                            clipped read answers with pixel 0 next cycle).
// -----------------------------------------------------------------------------
module syn_gpu_pxl_gw #(
  parameter int P_X_W    = 10,
  parameter int P_Y_W    = 9,
  parameter int P_PXL_W  = 16,
  parameter int P_FRM_W  = 640,
  parameter int P_FRM_H  = 480,
  parameter int P_ADDR_W = 19
) (
  input  logic                  clk_ir,
  input  logic                  rst_sync_l,
  syn_gpu_pxl_gw_pxl_if.slave   pif,
  syn_gpu_pxl_gw_sram_if.master sif,
  output logic [15:0]           drop_cnt
);

  typedef enum logic [1:0] {
    IDLE_S    = 2'd0,
    ISSUE_S   = 2'd1,
    RD_WAIT_S = 2'd2
  } state_t;

  state_t              state;
  logic                wr_acc;
  logic                rd_acc;
  logic                acc;
  logic                clip;
  logic [P_ADDR_W-1:0] addr_calc;

  // The whole frame must be addressable, otherwise pixels alias each other.
  if (P_FRM_W * P_FRM_H > (2 ** P_ADDR_W)) begin : g_frame_fit
    $error("syn_gpu_pxl_gw: frame does not fit in P_ADDR_W address bits");
  end

  // A write always wins over a simultaneous read; the read stays pending at
  // the requester until the gateway is idle again.
  assign pif.ready = (state == IDLE_S);
  assign wr_acc    = pif.pxl_wr_valid & pif.ready;
  assign rd_acc    = pif.pxl_rd_valid & ~pif.pxl_wr_valid & pif.ready;
  assign acc       = wr_acc | rd_acc;

  // Computed in the address width so the wrap-around is the natural truncation.
  assign addr_calc = P_ADDR_W'(pif.posy) * P_ADDR_W'(P_FRM_W) + P_ADDR_W'(pif.posx);

`ifdef SYN_GPU_PXL_GW_CLIP_EN
  // One extra bit so a frame dimension equal to 2**width still compares right.
  assign clip = ({1'b0, pif.posx} >= (P_X_W + 1)'(P_FRM_W)) ||
                ({1'b0, pif.posy} >= (P_Y_W + 1)'(P_FRM_H));

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      drop_cnt <= 16'd0;
    end else if (acc && clip && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign clip     = 1'b0;
  assign drop_cnt = 16'd0;
`endif

  // NOTE: every register below is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = here would let later statements
  // see half-updated state and the simulated order would leak into hardware.
  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      state            <= IDLE_S;
      sif.sram_req     <= 1'b0;
      sif.sram_we      <= 1'b0;
      sif.sram_addr    <= '0;
      sif.sram_wdata   <= '0;
      pif.rd_rsp_valid <= 1'b0;
      pif.rd_rsp_pxl   <= '0;
    end else begin
      pif.rd_rsp_valid <= 1'b0;
      unique case (state)
        IDLE_S: begin
          if (acc) begin
            if (clip) begin
              // Dropped request: stay idle, a read still gets an answer.
              if (rd_acc) begin
                pif.rd_rsp_valid <= 1'b1;
                pif.rd_rsp_pxl   <= '0;
              end
            end else begin
              state          <= ISSUE_S;
              sif.sram_req   <= 1'b1;
              sif.sram_we    <= wr_acc;
              sif.sram_addr  <= addr_calc;
              sif.sram_wdata <= pif.pxl;
            end
          end
        end
        ISSUE_S: begin
          // we/addr/wdata are left untouched so they stay stable under req.
          if (sif.sram_ack) begin
            sif.sram_req <= 1'b0;
            state        <= sif.sram_we ? IDLE_S : RD_WAIT_S;
          end
        end
        RD_WAIT_S: begin
          if (sif.sram_rd_valid) begin
            pif.rd_rsp_valid <= 1'b1;
            pif.rd_rsp_pxl   <= sif.sram_rdata;
            state            <= IDLE_S;
          end
        end
        default: state <= IDLE_S;
      endcase
    end
  end

endmodule

// File: tb/tb_syn_gpu_pxl_gw.sv
// -----------------------------------------------------------------------------
// tb_syn_gpu_pxl_gw.sv
// Self-checking bench for syn_gpu_pxl_gw. A vector table drives single
// transactions with programmable ack / read-data delays; read results are
// queued as expectations and matched by a response monitor. Hand-written
// sequences cover write/read collision, spurious ack / read-valid, and reset
// in the middle of a transaction. Follows SYN_GPU_PXL_GW_CLIP_EN if defined.
// -----------------------------------------------------------------------------
module tb_syn_gpu_pxl_gw;

  localparam int P_X_W    = 10;
  localparam int P_Y_W    = 9;
  localparam int P_PXL_W  = 16;
  localparam int P_FRM_W  = 640;
  localparam int P_FRM_H  = 480;
  localparam int P_ADDR_W = 19;

  logic        clk_ir     = 1'b0;
  logic        rst_sync_l = 1'b0;
  logic [15:0] drop_cnt;

  syn_gpu_pxl_gw_pxl_if  #(.P_X_W(P_X_W), .P_Y_W(P_Y_W), .P_PXL_W(P_PXL_W)) pif ();
  syn_gpu_pxl_gw_sram_if #(.P_PXL_W(P_PXL_W), .P_ADDR_W(P_ADDR_W))          sif ();

  syn_gpu_pxl_gw #(
    .P_X_W(P_X_W), .P_Y_W(P_Y_W), .P_PXL_W(P_PXL_W),
    .P_FRM_W(P_FRM_W), .P_FRM_H(P_FRM_H), .P_ADDR_W(P_ADDR_W)
  ) dut (
    .clk_ir    (clk_ir),
    .rst_sync_l(rst_sync_l),
    .pif       (pif),
    .sif       (sif),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk_ir = ~clk_ir;

  typedef struct {
    logic        is_wr;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [15:0] pxl;
    int          ack_dly;
    int          rd_dly;
    logic [15:0] rdata;
    logic [18:0] exp_addr;
    logic        clip;
  } vec_t;

  vec_t        vecs[7];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_drop = 16'd0;
  logic [15:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: every rd_rsp_valid pulse must match the oldest queued read.
  always @(negedge clk_ir) begin
    if (rst_sync_l && pif.rd_rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(pif.rd_rsp_valid), 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        check("rsp_pxl", 32'(pif.rd_rsp_pxl), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset(input string tag);
    check({tag, "_req"},     32'(sif.sram_req),     32'd0);
    check({tag, "_we"},      32'(sif.sram_we),      32'd0);
    check({tag, "_addr"},    32'(sif.sram_addr),    32'd0);
    check({tag, "_wdata"},   32'(sif.sram_wdata),   32'd0);
    check({tag, "_rspv"},    32'(pif.rd_rsp_valid), 32'd0);
    check({tag, "_rsppxl"},  32'(pif.rd_rsp_pxl),   32'd0);
    check({tag, "_drop"},    32'(drop_cnt),         32'd0);
    check({tag, "_ready"},   32'(pif.ready),        32'd1);
  endtask

  // Called at a negedge with the gateway idle; returns at a negedge, idle.
  task automatic do_txn(input vec_t v, input string tag);
    pif.posx         = v.x;
    pif.posy         = v.y;
    pif.pxl          = v.pxl;
    pif.pxl_wr_valid = v.is_wr;
    pif.pxl_rd_valid = ~v.is_wr;
    check({tag, "_ready_idle"}, 32'(pif.ready), 32'd1);
`ifdef SYN_GPU_PXL_GW_CLIP_EN
    if (v.clip) begin
      if (!v.is_wr) sb.push_back(16'h0000);
      if (exp_drop != 16'hFFFF) exp_drop++;
      @(negedge clk_ir);
      pif.pxl_wr_valid = 1'b0;
      pif.pxl_rd_valid = 1'b0;
      check({tag, "_clip_req"},   32'(sif.sram_req), 32'd0);
      check({tag, "_clip_ready"}, 32'(pif.ready),    32'd1);
      check({tag, "_clip_drop"},  32'(drop_cnt),     32'(exp_drop));
      if (!v.is_wr) check({tag, "_clip_rspv"}, 32'(pif.rd_rsp_valid), 32'd1);
      @(negedge clk_ir);
      return;
    end
`endif
    if (!v.is_wr) sb.push_back(v.rdata);
    @(negedge clk_ir);
    pif.pxl_wr_valid = 1'b0;
    pif.pxl_rd_valid = 1'b0;
    for (int k = 0; k <= v.ack_dly; k++) begin
      if (k != 0) @(negedge clk_ir);
      check({tag, "_req"},   32'(sif.sram_req),  32'd1);
      check({tag, "_we"},    32'(sif.sram_we),   32'(v.is_wr));
      check({tag, "_addr"},  32'(sif.sram_addr), 32'(v.exp_addr));
      check({tag, "_ready"}, 32'(pif.ready),     32'd0);
      if (v.is_wr) check({tag, "_wdata"}, 32'(sif.sram_wdata), 32'(v.pxl));
    end
    sif.sram_ack = 1'b1;
    @(negedge clk_ir);
    sif.sram_ack = 1'b0;
    check({tag, "_req_drop"}, 32'(sif.sram_req), 32'd0);
    if (v.is_wr) begin
      check({tag, "_ready_back"}, 32'(pif.ready), 32'd1);
    end else begin
      for (int k = 0; k < v.rd_dly; k++) begin
        check({tag, "_ready_rdwait"}, 32'(pif.ready), 32'd0);
        @(negedge clk_ir);
      end
      check({tag, "_ready_rdwait"}, 32'(pif.ready), 32'd0);
      sif.sram_rd_valid = 1'b1;
      sif.sram_rdata    = v.rdata;
      @(negedge clk_ir);
      sif.sram_rd_valid = 1'b0;
      sif.sram_rdata    = 16'hDEAD;
      check({tag, "_rspv"},       32'(pif.rd_rsp_valid), 32'd1);
      check({tag, "_ready_back"}, 32'(pif.ready),        32'd1);
    end
  endtask

  initial begin
    pif.pxl_wr_valid  = 1'b0;
    pif.pxl_rd_valid  = 1'b0;
    pif.posx          = '0;
    pif.posy          = '0;
    pif.pxl           = '0;
    sif.sram_ack      = 1'b0;
    sif.sram_rd_valid = 1'b0;
    sif.sram_rdata    = 16'hDEAD;

    //            wr    x        y        pxl       ack rd rdata     addr         clip
    vecs[0] = '{1'b1, 10'd10,  9'd2,   16'hABCD, 0,  0, 16'h0000, 19'd1290,   1'b0};
    vecs[1] = '{1'b0, 10'd639, 9'd479, 16'h0000, 3,  4, 16'h1234, 19'd307199, 1'b0};
    vecs[2] = '{1'b1, 10'd0,   9'd0,   16'h5A5A, 5,  0, 16'h0000, 19'd0,      1'b0};
    vecs[3] = '{1'b1, 10'd640, 9'd0,   16'hFFFF, 0,  0, 16'h0000, 19'd640,    1'b1};
    vecs[4] = '{1'b0, 10'd5,   9'd480, 16'h0000, 1,  0, 16'hBEEF, 19'd307205, 1'b1};
    vecs[5] = '{1'b0, 10'd100, 9'd100, 16'h0000, 0,  0, 16'hC3C3, 19'd64100,  1'b0};
    vecs[6] = '{1'b1, 10'd639, 9'd0,   16'h0001, 2,  0, 16'h0000, 19'd639,    1'b0};

    repeat (2) @(negedge clk_ir);
    check_reset("por");
    rst_sync_l = 1'b1;
    @(negedge clk_ir);

    for (int i = 0; i < 7; i++) begin
      do_txn(vecs[i], $sformatf("v%0d", i));
    end
    check("drop_after_table", 32'(drop_cnt), 32'(exp_drop));

    // Write and read together: write (3,1) goes first, read (20,3) is held.
    pif.posx = 10'd3; pif.posy = 9'd1; pif.pxl = 16'h7777;
    pif.pxl_wr_valid = 1'b1; pif.pxl_rd_valid = 1'b1;
    sb.push_back(16'h4242);
    @(negedge clk_ir);
    pif.pxl_wr_valid = 1'b0;
    pif.posx = 10'd20; pif.posy = 9'd3;
    check("coll_wr_req",   32'(sif.sram_req),   32'd1);
    check("coll_wr_we",    32'(sif.sram_we),    32'd1);
    check("coll_wr_addr",  32'(sif.sram_addr),  32'd643);
    check("coll_wr_wdata", 32'(sif.sram_wdata), 32'h7777);
    sif.sram_ack = 1'b1;
    @(negedge clk_ir);
    sif.sram_ack = 1'b0;
    check("coll_wr_done",  32'(sif.sram_req), 32'd0);
    check("coll_ready",    32'(pif.ready),    32'd1);
    @(negedge clk_ir);
    pif.pxl_rd_valid = 1'b0;
    check("coll_rd_req",   32'(sif.sram_req),  32'd1);
    check("coll_rd_we",    32'(sif.sram_we),   32'd0);
    check("coll_rd_addr",  32'(sif.sram_addr), 32'd1940);
    sif.sram_ack = 1'b1;
    @(negedge clk_ir);
    sif.sram_ack = 1'b0;
    sif.sram_rd_valid = 1'b1; sif.sram_rdata = 16'h4242;
    @(negedge clk_ir);
    sif.sram_rd_valid = 1'b0; sif.sram_rdata = 16'hDEAD;
    check("coll_rspv",     32'(pif.rd_rsp_valid), 32'd1);

    // Ack and read-valid while idle must be ignored.
    sif.sram_ack = 1'b1; sif.sram_rd_valid = 1'b1; sif.sram_rdata = 16'h9999;
    @(negedge clk_ir);
    sif.sram_ack = 1'b0; sif.sram_rd_valid = 1'b0; sif.sram_rdata = 16'hDEAD;
    check("idle_ack_req",   32'(sif.sram_req),     32'd0);
    check("idle_ack_ready", 32'(pif.ready),        32'd1);
    check("idle_rdv_rspv",  32'(pif.rd_rsp_valid), 32'd0);
    @(negedge clk_ir);

    // Reset while a write is in ISSUE_S.
    pif.posx = 10'd1; pif.posy = 9'd1; pif.pxl = 16'h1111; pif.pxl_wr_valid = 1'b1;
    @(negedge clk_ir);
    pif.pxl_wr_valid = 1'b0;
    check("rst_issue_pre", 32'(sif.sram_req), 32'd1);
    rst_sync_l = 1'b0;
    @(posedge clk_ir); #1;
    check_reset("rst_issue");
    @(negedge clk_ir);
    rst_sync_l = 1'b1;
    exp_drop = 16'd0;
    @(negedge clk_ir);
    check("rst_issue_idle", 32'(sif.sram_req), 32'd0);

    // Reset while a read waits for data; late data must produce no response.
    pif.posx = 10'd2; pif.posy = 9'd2; pif.pxl_rd_valid = 1'b1;
    @(negedge clk_ir);
    pif.pxl_rd_valid = 1'b0;
    check("rst_rd_addr", 32'(sif.sram_addr), 32'd1282);
    sif.sram_ack = 1'b1;
    @(negedge clk_ir);
    sif.sram_ack = 1'b0;
    check("rst_rd_wait", 32'(pif.ready), 32'd0);
    rst_sync_l = 1'b0;
    @(posedge clk_ir); #1;
    check_reset("rst_rdwait");
    @(negedge clk_ir);
    rst_sync_l = 1'b1;
    @(negedge clk_ir);
    sif.sram_rd_valid = 1'b1; sif.sram_rdata = 16'h5555;
    @(negedge clk_ir);
    sif.sram_rd_valid = 1'b0; sif.sram_rdata = 16'hDEAD;
    check("rst_rd_norsp", 32'(pif.rd_rsp_valid), 32'd0);
    check("rst_rd_ready", 32'(pif.ready),        32'd1);
    @(negedge clk_ir);

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("drop_final", 32'(drop_cnt),  32'(exp_drop));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
